// File: rtl/sa_cache_pkg.sv
// sa_cache_pkg: shared definitions for the 2-way set-associative cache.
// Holds the controller state encoding and the functions that derive the
// address-field widths from the SETS / WORDS parameters.
package sa_cache_pkg;

  // Controller states: idle/lookup, block fill from memory, write-through store.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Index width: log2(number of sets).
  function automatic int calc_idx_w(input int sets);
    return $clog2(sets);
  endfunction

  // Word-offset width: log2(words per block); zero for single-word blocks.
  function automatic int calc_off_w(input int words);
    return $clog2(words);
  endfunction

  // Tag width: whatever remains of the 30-bit word address.
  function automatic int calc_tag_w(input int sets, input int words);
    return 30 - $clog2(sets) - $clog2(words);
  endfunction

  // Width of the fill counter and word-select ports; at least one bit so
  // single-word blocks still have a legal (always zero) offset.
  function automatic int calc_cnt_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/sa_cache_way.sv
// sa_cache_way: storage for one way of the cache.
// Holds a valid bit, a tag and a data block per set. Reads are asynchronous
// (valid, tag and the selected word for the addressed set); writes are one
// word per clock; the valid bit is set together with the tag and all valid
// bits are cleared by clr_all.
// Ports:
//   clk        rising-edge clock
//   clr_all    synchronous clear of every valid bit
//   idx        set index used by the read port and both write ports
//   rd_off     word select for the read port
//   rd_valid   valid bit of the addressed set
//   rd_tag     stored tag of the addressed set
//   rd_word    selected data word of the addressed set
//   wr_en      write one data word
//   wr_off     word select for the data write
//   wr_data    data word to write
//   set_valid  mark the addressed set valid and store set_tag
//   set_tag    tag stored with set_valid
module sa_cache_way
  import sa_cache_pkg::*;
#(
  parameter int SETS  = 1024,
  parameter int WORDS = 2,
  localparam int IDX_W = calc_idx_w(SETS),
  localparam int TAG_W = calc_tag_w(SETS, WORDS),
  localparam int CNT_W = calc_cnt_w(WORDS)
) (
  input  logic             clk,
  input  logic             clr_all,
  input  logic [IDX_W-1:0] idx,
  input  logic [CNT_W-1:0] rd_off,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_word,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_off,
  input  logic [31:0]      wr_data,
  input  logic             set_valid,
  input  logic [TAG_W-1:0] set_tag
);

  logic [SETS-1:0]       valid_r;
  logic [TAG_W-1:0]      tag_r  [SETS];
  logic [WORDS*32-1:0]   data_r [SETS];

  // Valid bits: the only per-line state that must come up cleared.
  always_ff @(posedge clk) begin
    if (clr_all) begin
      valid_r <= {SETS{1'b0}};
    end else if (set_valid) begin
      valid_r[idx] <= 1'b1;
    end
  end

  // Tag and data arrays: no reset, contents are qualified by valid_r.
  always_ff @(posedge clk) begin
    if (set_valid) begin
      tag_r[idx] <= set_tag;
    end
    if (wr_en) begin
      data_r[idx][{wr_off, 5'd0} +: 32] <= wr_data;
    end
  end

  assign rd_valid = valid_r[idx];
  assign rd_tag   = tag_r[idx];
  assign rd_word  = data_r[idx][{rd_off, 5'd0} +: 32];

endmodule

// File: rtl/sa_cache.sv
// sa_cache: 2-way set-associative cache, per-set LRU replacement,
// read-allocate block fill, write-through / no-write-allocate stores.
// Lookup is combinational from cpu_addr; misses and stores stall the
// pipeline while a word-serial memory transaction runs.
// Ports:
//   CLK, RESET        rising-edge clock, synchronous active-high reset
//   cpu_req/we/addr   access request, store flag, byte address
//   cpu_wdata         store data
//   cpu_rdata         load data (valid when cpu_req & !cpu_we & !cpu_stall)
//   cpu_stall         pipeline hold
//   mem_req/we        memory transaction level / 1 = single-word write
//   mem_addr/wdata    block address (read) or word address + data (write)
//   mem_rvalid/rdata  read beat strobe and data
//   mem_ack           write completed
module sa_cache
  import sa_cache_pkg::*;
#(
  parameter int SETS  = 1024,
  parameter int WORDS = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int IDX_W = calc_idx_w(SETS);
  localparam int OFF_W = calc_off_w(WORDS);
  localparam int TAG_W = calc_tag_w(SETS, WORDS);
  localparam int CNT_W = calc_cnt_w(WORDS);

  // Address fields
  logic [TAG_W-1:0] tag_s;
  logic [IDX_W-1:0] idx_s;
  logic [CNT_W-1:0] off_s;
  logic [31:0]      blk_addr_s;
  logic [31:0]      word_addr_s;
  logic             addr_unused_s;

  // Way interface
  logic [1:0]       way_valid_s;
  logic [TAG_W-1:0] way_tag_s  [2];
  logic [31:0]      way_word_s [2];
  logic [1:0]       hit_s;
  logic             hit_any_s;

  // Control
  state_t           state_r;
  state_t           state_next_s;
  logic [SETS-1:0]  lru_r;
  logic [CNT_W-1:0] cnt_r;
  logic             cnt_last_s;
  logic             victim_r;
  logic             victim_sel_s;
  logic             stall_s;
  logic             lru_upd_s;
  logic             lru_val_s;
  logic [1:0]       wr_en_s;
  logic [1:0]       set_valid_s;
  logic [CNT_W-1:0] wr_off_s;
  logic [31:0]      wr_data_s;
  logic             victim_lat_s;
  logic             cnt_clr_s;
  logic             cnt_inc_s;

  assign tag_s         = cpu_addr[31 -: TAG_W];
  assign idx_s         = cpu_addr[OFF_W+2 +: IDX_W];
  assign blk_addr_s    = {tag_s, idx_s, {(OFF_W+2){1'b0}}};
  assign word_addr_s   = {cpu_addr[31:2], 2'b00};
  assign addr_unused_s = ^cpu_addr[1:0];

  // Single-word blocks have no offset field; the word select is tied to 0.
  generate
    if (OFF_W > 0) begin : g_off
      assign off_s = cpu_addr[2 +: OFF_W];
    end else begin : g_no_off
      assign off_s = 1'b0;
    end
  endgenerate

  generate
    for (genvar w = 0; w < 2; w++) begin : g_way
      sa_cache_way #(
        .SETS  (SETS),
        .WORDS (WORDS)
      ) u_way (
        .clk       (CLK),
        .clr_all   (RESET),
        .idx       (idx_s),
        .rd_off    (off_s),
        .rd_valid  (way_valid_s[w]),
        .rd_tag    (way_tag_s[w]),
        .rd_word   (way_word_s[w]),
        .wr_en     (wr_en_s[w]),
        .wr_off    (wr_off_s),
        .wr_data   (wr_data_s),
        .set_valid (set_valid_s[w]),
        .set_tag   (tag_s)
      );
      assign hit_s[w] = way_valid_s[w] & (way_tag_s[w] == tag_s);
    end
  endgenerate

  assign hit_any_s  = |hit_s;
  assign cpu_rdata  = hit_s[1] ? way_word_s[1] : way_word_s[0];
  assign cpu_stall  = stall_s;
  assign cnt_last_s = (cnt_r == CNT_W'(WORDS - 1));

  // Victim choice: fill an empty way first (way 0 preferred), else the LRU way.
  always_comb begin
    victim_sel_s = 1'b0;
    if (!way_valid_s[0]) begin
      victim_sel_s = 1'b0;
    end else if (!way_valid_s[1]) begin
      victim_sel_s = 1'b1;
    end else begin
      victim_sel_s = lru_r[idx_s];
    end
  end

  // Next-state and datapath control. Reset forces IDLE and blocks every
  // array write, so a beat arriving in the reset cycle cannot land.
  always_comb begin
    state_next_s = state_r;
    stall_s      = 1'b0;
    lru_upd_s    = 1'b0;
    lru_val_s    = 1'b0;
    wr_en_s      = 2'b00;
    set_valid_s  = 2'b00;
    wr_off_s     = off_s;
    wr_data_s    = cpu_wdata;
    victim_lat_s = 1'b0;
    cnt_clr_s    = 1'b0;
    cnt_inc_s    = 1'b0;
    if (RESET) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (cpu_req) begin
            if (cpu_we) begin
              stall_s      = 1'b1;
              state_next_s = WRITE;
            end else if (hit_any_s) begin
              // LRU bit names the victim: the way that was not just used.
              lru_upd_s = 1'b1;
              lru_val_s = ~hit_s[1];
            end else begin
              stall_s      = 1'b1;
              state_next_s = FILL;
              victim_lat_s = 1'b1;
              cnt_clr_s    = 1'b1;
            end
          end else begin
            state_next_s = IDLE;
          end
        end
        FILL: begin
          stall_s = 1'b1;
          if (mem_rvalid) begin
            cnt_inc_s         = 1'b1;
            wr_off_s          = cnt_r;
            wr_data_s         = mem_rdata;
            wr_en_s[victim_r] = 1'b1;
            if (cnt_last_s) begin
              set_valid_s[victim_r] = 1'b1;
              lru_upd_s             = 1'b1;
              lru_val_s             = ~victim_r;
              state_next_s          = IDLE;
            end else begin
              state_next_s = FILL;
            end
          end else begin
            state_next_s = FILL;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            state_next_s = IDLE;
            if (hit_any_s) begin
              wr_en_s   = hit_s;
              lru_upd_s = 1'b1;
              lru_val_s = ~hit_s[1];
            end else begin
              wr_en_s = 2'b00;
            end
          end else begin
            stall_s      = 1'b1;
            state_next_s = WRITE;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Per-set LRU bits.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lru_r <= {SETS{1'b0}};
    end else if (lru_upd_s) begin
      lru_r[idx_s] <= lru_val_s;
    end
  end

  // Fill beat counter and latched victim way.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_r    <= {CNT_W{1'b0}};
      victim_r <= 1'b0;
    end else begin
      if (cnt_clr_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_inc_s) begin
        cnt_r <= cnt_last_s ? {CNT_W{1'b0}} : cnt_r + 1'b1;
      end
      if (victim_lat_s) begin
        victim_r <= victim_sel_s;
      end
    end
  end

  // Memory-side outputs are registered from the next state, so mem_req
  // rises on entry to FILL/WRITE and falls on the return to IDLE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      mem_req   <= (state_next_s != IDLE);
      mem_we    <= (state_next_s == WRITE);
      mem_addr  <= (state_next_s == FILL)  ? blk_addr_s :
                   (state_next_s == WRITE) ? word_addr_s : 32'd0;
      mem_wdata <= (state_next_s == WRITE) ? cpu_wdata : 32'd0;
    end
  end

endmodule

// File: tb/tb_sa_cache.sv
// tb_sa_cache: self-checking bench for sa_cache. Two instances share the
// CPU-side stimulus (gated by sel): the data-side geometry (1024 x 2) and
// the instruction-side geometry (256 x 4). The reference model treats each
// set as a recency-ordered list of at most two resident tags, and main
// memory as a sparse word array that also supplies expected load data.
module tb_sa_cache;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        mem_rvalid, mem_ack;
  logic [31:0] mem_rdata;
  int          sel;

  logic        req_a, req_b, rv_a, rv_b, ack_a, ack_b;
  logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, b_rdata, b_mem_addr, b_mem_wdata;
  logic        a_stall, a_mem_req, a_mem_we, b_stall, b_mem_req, b_mem_we;
  logic        s_stall, s_mem_req, s_mem_we;
  logic [31:0] s_rdata, s_mem_addr, s_mem_wdata;

  assign req_a = cpu_req & (sel == 0);
  assign req_b = cpu_req & (sel == 1);
  assign rv_a  = mem_rvalid & (sel == 0);
  assign rv_b  = mem_rvalid & (sel == 1);
  assign ack_a = mem_ack & (sel == 0);
  assign ack_b = mem_ack & (sel == 1);

  assign s_stall     = (sel == 1) ? b_stall     : a_stall;
  assign s_mem_req   = (sel == 1) ? b_mem_req   : a_mem_req;
  assign s_mem_we    = (sel == 1) ? b_mem_we    : a_mem_we;
  assign s_rdata     = (sel == 1) ? b_rdata     : a_rdata;
  assign s_mem_addr  = (sel == 1) ? b_mem_addr  : a_mem_addr;
  assign s_mem_wdata = (sel == 1) ? b_mem_wdata : a_mem_wdata;

  sa_cache #(.SETS(1024), .WORDS(2)) dut_a (
    .CLK(clk), .RESET(rst), .cpu_req(req_a), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(a_rdata), .cpu_stall(a_stall),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rvalid(rv_a), .mem_rdata(mem_rdata), .mem_ack(ack_a)
  );

  sa_cache #(.SETS(256), .WORDS(4)) dut_b (
    .CLK(clk), .RESET(rst), .cpu_req(req_b), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(b_rdata), .cpu_stall(b_stall),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rvalid(rv_b), .mem_rdata(mem_rdata), .mem_ack(ack_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: per instance and set, MRU tag, LRU tag, resident count.
  int unsigned m_mru [2][1024];
  int unsigned m_lru [2][1024];
  int          m_n   [2][1024];
  logic [31:0] memw  [logic [31:0]];

  function automatic void mdl_clear();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 1024; i++) m_n[s][i] = 0;
  endfunction

  function automatic bit mdl_hit(input int s, input int idx, input int unsigned tg);
    return (m_n[s][idx] >= 1 && m_mru[s][idx] == tg) ||
           (m_n[s][idx] == 2 && m_lru[s][idx] == tg);
  endfunction

  // Make tg the most recently used entry, inserting it (and dropping the
  // least recently used one when full) if it is not resident.
  function automatic void mdl_use(input int s, input int idx, input int unsigned tg);
    if (m_n[s][idx] >= 1 && m_mru[s][idx] == tg) return;
    m_lru[s][idx] = m_mru[s][idx];
    m_mru[s][idx] = tg;
    if (m_n[s][idx] < 2) m_n[s][idx] = m_n[s][idx] + 1;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (memw.exists(a)) return memw[a];
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cpu_req = 1'b0; mem_rvalid = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    check_val("rst_stall", a_stall, 1'b0);
    check_val("rst_mem_req", a_mem_req, 1'b0);
    check_val("rst_mem_we", a_mem_we, 1'b0);
    check_val("rst_mem_addr", a_mem_addr, 32'd0);
    check_val("rst_mem_wdata", a_mem_wdata, 32'd0);
    check_val("rst_b_mem_req", b_mem_req, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mdl_clear();
  endtask

  // One CPU access on the selected instance, acting as main memory too.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_dly, input bit gaps);
    int words, iw, ow, idx, stall_n, beat, waited;
    int unsigned tg;
    logic [31:0] blk, waddr;
    bit hit, done, addr_chk;
    words = (sel == 1) ? 4 : 2;
    iw    = (sel == 1) ? 8 : 10;
    ow    = (sel == 1) ? 2 : 1;
    idx   = int'((addr >> (ow + 2)) & ((32'd1 << iw) - 32'd1));
    tg    = addr >> (iw + ow + 2);
    blk   = addr & ~(32'(words * 4) - 32'd1);
    waddr = {addr[31:2], 2'b00};
    hit   = mdl_hit(sel, idx, tg);
    stall_n = 0; beat = 0; waited = 0; done = 1'b0; addr_chk = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    while (!done) begin
      mem_rvalid = 1'b0; mem_ack = 1'b0;
      if (s_mem_req && !s_mem_we) begin
        if (!addr_chk) begin
          check_val("fill_addr", s_mem_addr, blk);
          addr_chk = 1'b1;
        end
        if (beat < words && (!gaps || $urandom_range(0, 2) != 0)) begin
          mem_rdata  = mem_rd(blk + 32'(beat * 4));
          mem_rvalid = 1'b1;
          beat++;
        end
      end else if (s_mem_req && s_mem_we) begin
        if (!addr_chk) begin
          check_val("wr_addr", s_mem_addr, waddr);
          check_val("wr_data", s_mem_wdata, wdata);
          addr_chk = 1'b1;
        end
        if (waited == ack_dly) begin
          mem_ack = 1'b1;
          memw[waddr] = wdata;
        end
        waited++;
      end
      #1;
      if (!s_stall) begin
        done = 1'b1;
      end else begin
        stall_n++;
        if (stall_n > 200) begin
          check_val("timeout_stall", s_stall, 1'b0);
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
    if (we) begin
      check_val("store_stall", stall_n, ack_dly + 1);
    end else begin
      if (hit) check_val("hit_stall", stall_n, 0);
      else if (!gaps) check_val("miss_stall", stall_n, words + 1);
      else check_val("miss_seen", (stall_n > 0), 1'b1);
      check_val("load_data", s_rdata, mem_rd(waddr));
    end
    if (!we || hit) mdl_use(sel, idx, tg);
    @(posedge clk); #1;
    cpu_req = 1'b0; mem_rvalid = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] ad, ix;
    int unsigned tg;
    int pick;
    rst = 1'b1; sel = 0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0;
    cpu_wdata = 32'd0; mem_rvalid = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    memw[32'h0000_1000] = 32'hAAAA_0000;
    memw[32'h0000_1004] = 32'hBBBB_0004;
    mdl_clear();
    repeat (2) @(posedge clk);
    do_reset();

    // Miss then hit, then the conflict sequence at index 0x200.
    access(1'b0, 32'h0000_1004, 32'd0, 0, 1'b0);
    access(1'b0, 32'h0000_1004, 32'd0, 0, 1'b0);
    access(1'b0, 32'h0000_3004, 32'd0, 0, 1'b0);
    access(1'b0, 32'h0000_1004, 32'd0, 0, 1'b0);
    access(1'b0, 32'h0000_5004, 32'd0, 0, 1'b0);
    access(1'b0, 32'h0000_1004, 32'd0, 0, 1'b0);
    access(1'b0, 32'h0000_3004, 32'd0, 0, 1'b0);

    // Store to a resident word with a delayed ack, then read it back.
    access(1'b0, 32'h0000_1000, 32'd0, 0, 1'b0);
    access(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 3, 1'b0);
    access(1'b0, 32'h0000_1000, 32'd0, 0, 1'b0);

    // Store miss allocates nothing: the following load misses.
    access(1'b1, 32'h0000_7000, 32'h1234_5678, 0, 1'b0);
    access(1'b0, 32'h0000_7000, 32'd0, 0, 1'b0);

    // Reset on the second beat of a fill, with late beats afterwards.
    do_reset();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1004;
    #1 check_val("rf_miss_stall", a_stall, 1'b1);
    @(negedge clk);
    check_val("rf_req_up", a_mem_req, 1'b1);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_0000;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h2222_0004; rst = 1'b1;
    @(posedge clk); #1;
    check_val("rf_req_drop", a_mem_req, 1'b0);
    @(negedge clk);
    rst = 1'b0; cpu_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h3333_0000;
    #1 check_val("rf_idle_stall", a_stall, 1'b0);
    check_val("rf_idle_req", a_mem_req, 1'b0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    mdl_clear();
    access(1'b0, 32'h0000_1004, 32'd0, 0, 1'b0);

    // Randomised mix of loads and stores over a few conflicting sets.
    for (int i = 0; i < 300; i++) begin
      tg   = $urandom_range(0, 3);
      pick = $urandom_range(0, 2);
      ix   = (pick == 0) ? 32'h200 : (pick == 1) ? 32'h201 : 32'h003;
      ad   = (32'(tg) << 13) | (ix << 3) | (32'($urandom_range(0, 1)) << 2);
      if ($urandom_range(0, 3) == 0)
        access(1'b1, ad, $urandom, $urandom_range(0, 3), 1'b0);
      else
        access(1'b0, ad, 32'd0, 0, 1'($urandom_range(0, 1)));
    end

    // Instruction-side geometry: 4-beat fill, word 2 returned.
    sel = 1;
    access(1'b0, 32'h0000_0408, 32'd0, 0, 1'b0);
    access(1'b0, 32'h0000_0408, 32'd0, 0, 1'b0);
    access(1'b0, 32'h0000_040C, 32'd0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
